// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable clock divider with clean start/stop
// sequencing and ratio changes that only land on period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clkout,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic accept, legal, wrap;

  // High phase length (N+1)>>1, computed one bit wider so N=2^CNT_W-1 cannot overflow.
  function automatic logic [CNT_W:0] high_len(input logic [CNT_W-1:0] n);
    return ({1'b0, n} + 1'b1) >> 1;
  endfunction

  // A ratio is only taken while nothing is pending; sub-2 ratios are flagged and dropped.
  assign accept = div_valid && !pend_vld_q;
  assign legal  = accept && (div_in >= MIN_DIV);
  assign wrap   = (cnt_q == div_q - 1'b1);

  // Next-state: sequencing, counter, ratio application and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_d      = 1'b0;
    tick_d     = 1'b0;
    err_d      = accept && !legal;

    case (state_q)
      S_IDLE: begin
        // Idle sits on a boundary, so any ratio can land immediately and the
        // first period after en already uses it.
        if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
        if (legal) div_d = div_in;
        if (en) state_d = S_RUN;
      end
      default: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
          end
          state_d = en ? S_RUN : S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = en ? S_RUN : S_DRAIN;
        end
        // Captured after the wrap decision so a same-cycle offer waits one period.
        if (legal) begin
          pend_d     = div_in;
          pend_vld_d = 1'b1;
        end
      end
    endcase

    // clkout/tick are derived from the next count and ratio so they stay aligned with cnt.
    if (state_d != S_IDLE) begin
      clk_d  = ({1'b0, cnt_d} < high_len(div_d));
      tick_d = (cnt_d == '0);
    end
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DEF_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign div_ready  = !pend_vld_q;
  assign clkout     = clk_q;
  assign tick       = tick_q;
  assign div_active = div_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: period-level reference model checked every cycle,
// plus directed scenarios with literal waveform expectations.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;
  localparam int DEF   = 6;

  logic             clkin = 1'b0;
  logic             rst, en, div_valid;
  logic [CNT_W-1:0] div_in;
  logic             div_ready, clkout, tick, busy, err;
  logic [CNT_W-1:0] div_active;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clkin(clkin), .rst(rst), .en(en), .div_in(div_in), .div_valid(div_valid),
    .div_ready(div_ready), .clkout(clkout), .tick(tick), .div_active(div_active),
    .busy(busy), .err(err)
  );

  always #5 clkin = ~clkin;

  // Reference model: "active" flag, position within period, ratio, pending ratio.
  int m_n = DEF, m_pos = 0, m_pend = 0;
  bit m_act = 0, m_pv = 0, m_err = 0;

  always @(posedge clkin) begin : model
    int n, pos, p;
    bit act, pv, e, acc;
    n = m_n; pos = m_pos; p = m_pend; act = m_act; pv = m_pv; e = 0;
    if (rst) begin
      n = DEF; pos = 0; act = 0; pv = 0;
    end else begin
      acc = div_valid && !m_pv;
      e   = acc && (int'(div_in) < 2);
      if (!act) begin
        if (pv) begin n = p; pv = 0; end
        if (acc && !e) n = int'(div_in);
        if (en) begin act = 1; pos = 0; end
      end else begin
        if (pos == n - 1) begin
          if (pv) begin n = p; pv = 0; end
          pos = 0;
          if (!en) act = 0;
        end else begin
          pos = pos + 1;
        end
        if (acc && !e) begin p = int'(div_in); pv = 1; end
      end
    end
    m_n <= n; m_pos <= pos; m_pend <= p; m_act <= act; m_pv <= pv; m_err <= e;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clkin) begin : compare
    logic [12:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {m_act && (m_pos < (m_n + 1) / 2), m_act && (m_pos == 0), m_act,
               !m_pv, m_err, CNT_W'(m_n)};
      act_v = {clkout, tick, busy, div_ready, err, div_active};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h (clk,tick,busy,rdy,err,div)", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Records n cycles of clkout/tick starting at the current negedge, MSB first.
  task automatic sample(input int n, output logic [31:0] ck, output logic [31:0] tk);
    ck = '0; tk = '0;
    for (int i = 0; i < n; i++) begin
      ck = {ck[30:0], clkout};
      tk = {tk[30:0], tick};
      @(negedge clkin);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic wait_tick(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clkin);
      if (tick === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s got no tick want tick within 40 cycles", name);
    end
  endtask

  task automatic offer(input logic [CNT_W-1:0] v);
    div_valid = 1'b1; div_in = v;
    @(negedge clkin);
    div_valid = 1'b0;
  endtask

  logic [31:0] ck, tk;

  initial begin
    rst = 1'b1; en = 1'b0; div_valid = 1'b0; div_in = '0;
    step(2);
    chk_en = 1'b1;
    chk("rst_clkout", clkout, 0);
    chk("rst_div_active", div_active, 6);
    chk("rst_ready", div_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(1);

    // Default ratio 6: 111000 repeating, tick on first cycle of each period.
    en = 1'b1;
    step(1);
    sample(12, ck, tk);
    chk("n6_clkout", ck, 32'b111000111000);
    chk("n6_tick", tk, 32'b100000100000);

    // Switch to 4 offered mid-period at cnt=2.
    step(2);
    offer(4);
    chk("n4_ready_low", div_ready, 0);
    sample(11, ck, tk);
    chk("n4_seq", ck, 32'b00011001100);
    chk("n4_active", div_active, 4);

    // Back to 6, then offer 8 exactly on the wrap cycle.
    offer(6);
    step(3);
    step(5);
    offer(8);
    chk("wrap_ready_low", div_ready, 0);
    chk("wrap_active_still6", div_active, 6);
    sample(14, ck, tk);
    chk("wrap_seq", ck, 32'b11100011110000);

    // Illegal ratios.
    offer(1);
    chk("err_n1", err, 1);
    chk("err_n1_ready", div_ready, 1);
    step(1);
    chk("err_clear", err, 0);
    offer(0);
    chk("err_n0", err, 1);
    step(1);
    chk("err_active_kept", div_active, 8);

    // Return to 6, then drop en at cnt=1.
    wait_tick("sync_n8");
    offer(6);
    wait_tick("sync_n6");
    chk("drain_active", div_active, 6);
    step(1);
    en = 1'b0;
    step(1);
    sample(6, ck, tk);
    chk("drain_seq", ck, 32'b100000);
    chk("drain_busy", busy, 0);

    // Re-raise en during drain: no gap.
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    sample(9, ck, tk);
    chk("rerun_seq", ck, 32'b000111000);

    // Reset mid-period with a pending ratio.
    offer(4);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mrst_clkout", clkout, 0);
    chk("mrst_active", div_active, 6);
    chk("mrst_ready", div_ready, 1);
    rst = 1'b0;
    step(1);
    sample(6, ck, tk);
    chk("mrst_seq", ck, 32'b111000);

    // Stop, then in idle offer 5 together with en.
    en = 1'b0;
    step(6);
    chk("idle_busy", busy, 0);
    en = 1'b1;
    offer(5);
    chk("idle_active5", div_active, 5);
    chk("idle_ready", div_ready, 1);
    sample(10, ck, tk);
    chk("n5_seq", ck, 32'b1110011100);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time programmable clock-divider controller.
- Generates a divided clock `clkout` plus a one-cycle `tick` from `clkin`.
- Sequences start/stop cleanly: periods are never truncated.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a period boundary, so no runt or stretched pulses appear.
- Sits between configuration logic and all divided-clock consumers, replacing fixed-ratio dividers.

Parameters:
- CNT_W, 8: width of the divide ratio and internal counter.
- DEFAULT_DIV, 6: ratio loaded at reset; legal range 2..2^CNT_W-1.

Ports:
- clkin  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run request; 1 = run, 0 = stop at end of current period.
- div_in  input  CNT_W  requested divide ratio N.
- div_valid  input  1  div_in valid.
- div_ready  output  1  controller can accept div_in.
- clkout  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse coincident with each clkout rising cycle.
- div_active  output  CNT_W  ratio currently in use.
- busy  output  1  1 in RUN or DRAIN.
- err  output  1  one-cycle pulse when an illegal ratio is offered.

Behaviour:
- Reset (clkin edge with rst=1):
  - state=IDLE, cnt=0, clkout=0, tick=0, err=0, div_ready=1, busy=0.
  - div_active=DEFAULT_DIV.
  - Any pending ratio is discarded.
  - rst overrides every other input, including mid-period.
- Period definition for ratio N:
  - Period = N clkin cycles; cnt runs 0..N-1 and wraps to 0.
  - High phase H=(N+1)>>1. clkout=1 while cnt<H, else 0.
  - clkout and cnt are registered together, so clkout always reflects the current cnt.
  - Even N gives 50% duty. Odd N gives high (N+1)/2, low (N-1)/2.
- tick:
  - 1 for exactly the cycles where cnt=0 in RUN/DRAIN.
  - Equals the rising cycle of clkout.
- States:
  - IDLE: clkout=0, cnt=0, busy=0. If en=1 -> RUN. On the next edge cnt=0, clkout=1, tick=1 (1-cycle start latency).
  - RUN: count normally.
    - en=0 sampled -> DRAIN, and the current period completes.
    - At wrap (cnt=N-1), a pending ratio is loaded into div_active and the new period uses it.
  - DRAIN: keep counting.
    - en=1 -> RUN with no gap or phase change.
    - At cnt=N-1 with en=0 -> IDLE. clkout=0 and cnt=0 next cycle, and any pending ratio is applied to div_active then.
- Ratio handshake:
  - Transfer occurs when div_valid and div_ready are both 1.
  - div_in<2 is illegal: err=1 next cycle, value dropped, div_ready stays 1.
  - In IDLE: a legal ratio is written to div_active on the accepting edge and div_ready stays 1. If en=1 in the same cycle, the first period uses the new ratio.
  - In RUN/DRAIN: a legal ratio is held in a pending register and div_ready=0 until it is applied.
  - A ratio accepted in the same cycle as a wrap is not applied at that wrap; it applies at the next one.
  - div_ready returns to 1 the cycle after application.
- div_active changes only at the boundaries listed above, never mid-period.
- Arithmetic:
  - Unsigned CNT_W-bit; cnt never exceeds div_active-1.
  - Maximum N=2^CNT_W-1, so no overflow.

Test Plan:
- Reset, then en=1 with default N=6 -> clkout sequence 111000 repeating; tick every 6 cycles; first tick 1 cycle after en; busy=1.
- In IDLE offer N=5 with en=1 in the same cycle -> first period is 11100; div_active=5 immediately; div_ready never drops.
- In RUN at N=6, offer N=4 at cnt=2 -> div_ready=0; current period finishes as 6 cycles; next period is 1100; div_ready=1 one cycle after the switch.
- Offer N=8 in the exact cycle cnt=5 (wrap) -> next period still 6; the following period is 8 (11110000).
- Offer N=1 and N=0 -> err pulses once each; div_active unchanged; div_ready stays 1.
- en low at cnt=1 (N=6) -> period completes through cnt=5, then clkout=0 and busy=0. Separately, re-raise en during DRAIN -> no gap.
- Assert rst at cnt=2 -> next cycle clkout=0, div_active=6, pending cleared.
